// File: rtl/glitch_pkg.sv
// Shared types and clock-rate constants for the glitch trigger path.
package glitch_pkg;

   localparam int unsigned PLL_CLK_HZ    = 204_000_000;
   localparam int unsigned PLL_PERIOD_PS = 1_000_000_000 / (PLL_CLK_HZ / 1000);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      QUAL,
      FIRE_LO,
      FIRE_HI,
      HOLDOFF
   } qual_state_e;

   typedef enum logic {
      RISING  = 1'b0,
      FALLING = 1'b1
   } edge_sel_e;

endpackage

// File: rtl/trig_sync.sv
// Two-flop synchronizer with a previous-value stage for edge detection.
module trig_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level  = sync_q;
   assign rise_c = sync_q & ~prev_q;
   assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/trigger_qualifier.sv
// Qualifies external trigger edges by polarity and width, fires on the Nth one,
// then handshakes with the glitch generator and enforces a holdoff.
module trigger_qualifier
   import glitch_pkg::*;
#(
   parameter int unsigned FILTER_CYCLES  = 4,
   parameter int unsigned HOLDOFF_CYCLES = 1024,
   parameter int unsigned DONE_TIMEOUT   = 2**24,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig_raw,
   input  logic             arm,
   input  logic             edge_sel,
   input  logic [CNT_W-1:0] edge_count,
   input  logic             done_in,
   output logic             trig_out,
   output logic             armed,
   output logic             fired,
   output logic             timeout,
   output logic [CNT_W-1:0] edges_seen
);

   localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
   localparam int unsigned WAIT_W = $clog2(DONE_TIMEOUT + 1);

   qual_state_e      state_q, state_d;
   logic [FILT_W-1:0] filt_q, filt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  edges_q, edges_d;
   logic [CNT_W-1:0]  target_q, target_d;
   edge_sel_e         sel_q, sel_d;
   logic              trig_out_q, trig_out_d;
   logic              armed_q, armed_d;
   logic              fired_q, fired_d;
   logic              timeout_q, timeout_d;

   logic              trig_lvl, trig_rise_c, trig_fall_c;
   logic              sel_edge_c, new_lvl_c, qual_c, wait_done_c;
   logic [FILT_W-1:0] filt_inc_c;
   logic [HOLD_W-1:0] hold_inc_c;
   logic [WAIT_W-1:0] wait_inc_c;
   logic [CNT_W-1:0]  edges_inc_c;

   trig_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (trig_raw),
      .level    (trig_lvl),
      .rise_c   (trig_rise_c),
      .fall_c   (trig_fall_c)
   );

   // Edge/level views relative to the latched polarity.
   always_comb begin
      sel_edge_c  = (sel_q == FALLING) ? trig_fall_c : trig_rise_c;
      new_lvl_c   = (sel_q == FALLING) ? ~trig_lvl : trig_lvl;
      filt_inc_c  = filt_q + FILT_W'(1);
      hold_inc_c  = hold_q + HOLD_W'(1);
      wait_inc_c  = wait_q + WAIT_W'(1);
      wait_done_c = (wait_inc_c == WAIT_W'(DONE_TIMEOUT));
      edges_inc_c = (edges_q == {CNT_W{1'b1}}) ? edges_q : edges_q + CNT_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      filt_d    = filt_q;
      hold_d    = hold_q;
      wait_d    = wait_q;
      edges_d   = edges_q;
      target_d  = target_q;
      sel_d     = sel_q;
      fired_d   = 1'b0;
      timeout_d = 1'b0;
      qual_c    = 1'b0;

      case (state_q)
         IDLE: begin
            if (arm) begin
               state_d  = ARMED;
               edges_d  = '0;
               sel_d    = edge_sel_e'(edge_sel);
               target_d = (edge_count == '0) ? CNT_W'(1) : edge_count;
            end
         end
         ARMED: begin
            if (!arm) begin
               state_d = IDLE;
            end else if (sel_edge_c) begin
               if (FILTER_CYCLES == 1) begin
                  qual_c = 1'b1;
               end else begin
                  state_d = QUAL;
                  filt_d  = FILT_W'(1);
               end
            end
         end
         QUAL: begin
            if (!arm) begin
               state_d = IDLE;
            end else if (!new_lvl_c) begin
               state_d = ARMED;
            end else if (filt_inc_c == FILT_W'(FILTER_CYCLES)) begin
               qual_c = 1'b1;
            end else begin
               filt_d = filt_inc_c;
            end
         end
         FIRE_LO: begin
            if (!done_in) begin
               state_d = FIRE_HI;
               wait_d  = '0;
            end else if (wait_done_c) begin
               state_d   = HOLDOFF;
               hold_d    = '0;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_inc_c;
            end
         end
         FIRE_HI: begin
            if (done_in) begin
               state_d = HOLDOFF;
               hold_d  = '0;
            end else if (wait_done_c) begin
               state_d   = HOLDOFF;
               hold_d    = '0;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_inc_c;
            end
         end
         HOLDOFF: begin
            if (hold_inc_c == HOLD_W'(HOLDOFF_CYCLES)) begin
               state_d = arm ? ARMED : IDLE;
               edges_d = '0;
            end else begin
               hold_d = hold_inc_c;
            end
         end
         default: state_d = IDLE;
      endcase

      // A qualified edge either completes the count and fires, or re-arms.
      if (qual_c) begin
         edges_d = edges_inc_c;
         if (edges_inc_c == target_q) begin
            state_d = FIRE_LO;
            wait_d  = '0;
            fired_d = 1'b1;
         end else begin
            state_d = ARMED;
         end
      end

      trig_out_d = (state_d == FIRE_LO) || (state_d == FIRE_HI);
      armed_d    = (state_d == ARMED) || (state_d == QUAL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         filt_q     <= '0;
         hold_q     <= '0;
         wait_q     <= '0;
         edges_q    <= '0;
         target_q   <= '0;
         sel_q      <= RISING;
         trig_out_q <= 1'b0;
         armed_q    <= 1'b0;
         fired_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         filt_q     <= filt_d;
         hold_q     <= hold_d;
         wait_q     <= wait_d;
         edges_q    <= edges_d;
         target_q   <= target_d;
         sel_q      <= sel_d;
         trig_out_q <= trig_out_d;
         armed_q    <= armed_d;
         fired_q    <= fired_d;
         timeout_q  <= timeout_d;
      end
   end

   assign trig_out   = trig_out_q;
   assign armed      = armed_q;
   assign fired      = fired_q;
   assign timeout    = timeout_q;
   assign edges_seen = edges_q;

endmodule

// File: tb/tb_trigger_qualifier.sv
// Directed bench for trigger_qualifier: filtering, Nth-edge firing, handshake,
// timeout, holdoff and reset/arm behaviour.
module tb_trigger_qualifier;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             trig_raw;
   logic             arm;
   logic             edge_sel;
   logic [CNT_W-1:0] edge_count;
   logic             done_in;
   logic             trig_out;
   logic             armed;
   logic             fired;
   logic             timeout;
   logic [CNT_W-1:0] edges_seen;

   int tests = 0;
   int fails = 0;

   trigger_qualifier #(
      .FILTER_CYCLES  (4),
      .HOLDOFF_CYCLES (1024),
      .DONE_TIMEOUT   (16),
      .CNT_W          (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .trig_raw   (trig_raw),
      .arm        (arm),
      .edge_sel   (edge_sel),
      .edge_count (edge_count),
      .done_in    (done_in),
      .trig_out   (trig_out),
      .armed      (armed),
      .fired      (fired),
      .timeout    (timeout),
      .edges_seen (edges_seen)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; trig_raw = 1'b0; arm = 1'b0; edge_sel = 1'b0;
      edge_count = 16'd1; done_in = 1'b1;
      tick(2);
      chk1("rst_trig_out", trig_out, 1'b0);
      chk1("rst_armed", armed, 1'b0);
      chk1("rst_fired", fired, 1'b0);
      chk1("rst_timeout", timeout, 1'b0);
      chkn("rst_edges", edges_seen, 16'd0);
      rst = 1'b0;

      // Single rising edge, count 1, full handshake.
      arm = 1'b1;
      tick(1);
      chk1("arm_armed", armed, 1'b1);
      tick(2);
      trig_raw = 1'b1;
      tick(5);
      chk1("t1_lat_lo", trig_out, 1'b0);
      tick(1);
      chk1("t1_trig_out", trig_out, 1'b1);
      chk1("t1_fired", fired, 1'b1);
      chkn("t1_edges", edges_seen, 16'd1);
      chk1("t1_armed", armed, 1'b0);
      tick(1);
      chk1("t1_fired_pulse", fired, 1'b0);
      chk1("t1_fire_lo_hold", trig_out, 1'b1);
      done_in = 1'b0;
      tick(1);
      chk1("t1_fire_hi", trig_out, 1'b1);
      done_in = 1'b1;
      tick(1);
      chk1("t1_trig_fall", trig_out, 1'b0);
      chk1("t1_no_timeout", timeout, 1'b0);
      trig_raw = 1'b0;
      tick(1023);
      chk1("t1_holdoff_end_m1", armed, 1'b0);
      tick(1);
      chk1("t1_rearmed", armed, 1'b1);
      chkn("t1_edges_clr", edges_seen, 16'd0);

      // Glitch rejection with count 2.
      arm = 1'b0;
      tick(1);
      chk1("t2_disarm", armed, 1'b0);
      edge_count = 16'd2; edge_sel = 1'b0; arm = 1'b1;
      tick(1);
      chk1("t2_armed", armed, 1'b1);
      trig_raw = 1'b1;
      tick(3);
      trig_raw = 1'b0;
      tick(6);
      chkn("t2_glitch_rej", edges_seen, 16'd0);
      chk1("t2_glitch_armed", armed, 1'b1);
      trig_raw = 1'b1;
      tick(4);
      trig_raw = 1'b0;
      tick(1);
      chkn("t2_qual_m1", edges_seen, 16'd0);
      tick(1);
      chkn("t2_qual", edges_seen, 16'd1);
      chk1("t2_no_fire", trig_out, 1'b0);
      chk1("t2_still_armed", armed, 1'b1);

      // Third falling edge fires; edges 4-5 land in holdoff.
      arm = 1'b0;
      tick(1);
      edge_sel = 1'b1; edge_count = 16'd3; trig_raw = 1'b1;
      tick(4);
      arm = 1'b1;
      tick(1);
      chkn("t3_edges_clr", edges_seen, 16'd0);
      trig_raw = 1'b0;
      tick(8);
      chkn("t3_edge1", edges_seen, 16'd1);
      trig_raw = 1'b1;
      tick(8);
      trig_raw = 1'b0;
      tick(8);
      chkn("t3_edge2", edges_seen, 16'd2);
      chk1("t3_edge2_nofire", trig_out, 1'b0);
      trig_raw = 1'b1;
      tick(8);
      trig_raw = 1'b0;
      tick(5);
      chk1("t3_lat_lo", trig_out, 1'b0);
      tick(1);
      chk1("t3_fire", trig_out, 1'b1);
      chk1("t3_fired", fired, 1'b1);
      chkn("t3_edges3", edges_seen, 16'd3);
      tick(2);
      done_in = 1'b0;
      tick(1);
      done_in = 1'b1;
      tick(1);
      chk1("t3_trig_fall", trig_out, 1'b0);
      for (int i = 0; i < 5; i++) begin
         trig_raw = ~trig_raw;
         tick(8);
      end
      chkn("t3_holdoff_ign", edges_seen, 16'd3);
      chk1("t3_holdoff_nofire", trig_out, 1'b0);
      tick(983);
      chk1("t3_holdoff_m1", armed, 1'b0);
      tick(1);
      chk1("t3_rearmed", armed, 1'b1);
      chkn("t3_edges_clr2", edges_seen, 16'd0);

      // Count 0 acts as 1; done_in held high keeps FIRE_LO.
      arm = 1'b0;
      tick(1);
      edge_count = 16'd0; edge_sel = 1'b0; trig_raw = 1'b0;
      tick(4);
      arm = 1'b1;
      tick(1);
      trig_raw = 1'b1;
      tick(5);
      chk1("t4_lat_lo", trig_out, 1'b0);
      tick(1);
      chk1("t4_fire", trig_out, 1'b1);
      chkn("t4_edges", edges_seen, 16'd1);
      tick(5);
      chk1("t4_fire_lo_wait", trig_out, 1'b1);
      chk1("t4_no_timeout", timeout, 1'b0);
      done_in = 1'b0;
      tick(1);
      chk1("t4_fire_hi", trig_out, 1'b1);
      tick(3);
      chk1("t4_fire_hi_wait", trig_out, 1'b1);
      done_in = 1'b1;
      tick(1);
      chk1("t4_trig_fall", trig_out, 1'b0);
      tick(1024);
      chk1("t4_rearmed", armed, 1'b1);

      // done_in stuck high: timeout after 16 cycles in FIRE_LO.
      trig_raw = 1'b0;
      tick(4);
      trig_raw = 1'b1;
      tick(6);
      chk1("t5_fired", fired, 1'b1);
      tick(15);
      chk1("t5_to_m1", timeout, 1'b0);
      chk1("t5_trig_m1", trig_out, 1'b1);
      tick(1);
      chk1("t5_timeout", timeout, 1'b1);
      chk1("t5_trig_low", trig_out, 1'b0);
      tick(1);
      chk1("t5_to_pulse", timeout, 1'b0);
      chk1("t5_holdoff", armed, 1'b0);
      tick(1022);
      chk1("t5_holdoff_m1", armed, 1'b0);
      tick(1);
      chk1("t5_rearmed", armed, 1'b1);

      // Reset during FIRE_HI.
      trig_raw = 1'b0;
      tick(4);
      trig_raw = 1'b1;
      tick(6);
      chk1("t6_fired", fired, 1'b1);
      done_in = 1'b0;
      tick(1);
      chk1("t6_fire_hi", trig_out, 1'b1);
      rst = 1'b1;
      tick(1);
      chk1("t6_rst_trig", trig_out, 1'b0);
      chk1("t6_rst_armed", armed, 1'b0);
      chk1("t6_rst_fired", fired, 1'b0);
      chk1("t6_rst_timeout", timeout, 1'b0);
      chkn("t6_rst_edges", edges_seen, 16'd0);
      rst = 1'b0; done_in = 1'b1;
      tick(1);
      chk1("t6_rearm", armed, 1'b1);

      // arm dropped in QUAL: back to IDLE, edge not counted.
      trig_raw = 1'b0;
      tick(4);
      trig_raw = 1'b1;
      tick(3);
      chk1("t7_in_qual", armed, 1'b1);
      arm = 1'b0;
      tick(1);
      chk1("t7_idle", armed, 1'b0);
      tick(4);
      chk1("t7_no_fire", trig_out, 1'b0);
      chkn("t7_no_count", edges_seen, 16'd0);

      // arm dropped in FIRE_HI: shot completes, then IDLE.
      arm = 1'b1; trig_raw = 1'b0;
      tick(4);
      trig_raw = 1'b1;
      tick(6);
      chk1("t8_fired", fired, 1'b1);
      done_in = 1'b0;
      tick(1);
      arm = 1'b0;
      tick(2);
      chk1("t8_shot_cont", trig_out, 1'b1);
      done_in = 1'b1;
      tick(1);
      chk1("t8_trig_fall", trig_out, 1'b0);
      tick(1023);
      chkn("t8_edges_hold", edges_seen, 16'd1);
      tick(1);
      chkn("t8_edges_clr", edges_seen, 16'd0);
      chk1("t8_idle", armed, 1'b0);
      arm = 1'b1;
      tick(1);
      chk1("t8_idle_rearm", armed, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/trigger_qualifier.md
# trigger_qualifier

Conditions the raw external trigger before it reaches the glitch generator.
- Synchronizes the trigger and qualifies edges by polarity and minimum stable width.
- Counts qualified edges and fires on the Nth one.
- Holds its trigger output high until the glitch generator reports completion, then enforces a holdoff before re-arming.
- Sits directly upstream of the glitch generator, in the same 204 MHz PLL clock domain; `trig_out` drives its `trigger` input and its `done_indicator` returns on `done_in`.

## Interface
Parameters:
- `FILTER_CYCLES`, 4: consecutive synced cycles a new level must persist to qualify an edge (≥1).
- `HOLDOFF_CYCLES`, 1024: dead time after a shot before accepting new edges (≥1).
- `DONE_TIMEOUT`, 2**24: max cycles spent waiting on `done_in` per phase.
- `CNT_W`, 16: width of edge counters.

Ports:
- `clk` in 1: PLL clock (same net that clocks the glitch generator).
- `rst` in 1: one clock; reset is synchronous and active-high.
- `trig_raw` in 1: asynchronous external trigger.
- `arm` in 1: level; enables qualification.
- `edge_sel` in 1: 0 = rising, 1 = falling.
- `edge_count` in CNT_W: fire on this qualified edge; 0 is treated as 1.
- `done_in` in 1: glitch generator done level.
- `trig_out` out 1: trigger level to the glitch generator.
- `armed` out 1: high in ARMED/QUAL.
- `fired` out 1: one-cycle pulse when `trig_out` rises.
- `timeout` out 1: one-cycle pulse on done-wait expiry.
- `edges_seen` out CNT_W: qualified edges in the current arming.

## Operation
- Sync: 2-FF synchronizer on `trig_raw`, followed by a previous-value register for edge detection. All three flops reset to 0.
- `edge_sel` and `edge_count` are latched on the IDLE→ARMED transition and ignored at all other times.
- States:
  - IDLE: `arm`=1 → ARMED; clear `edges_seen`.
  - ARMED: a selected edge on the synced signal → QUAL with filter count = 1. `arm`=0 → IDLE.
  - QUAL:
    - Synced level reverts → ARMED; the edge is not counted.
    - Count reaches FILTER_CYCLES → qualified: `edges_seen`++.
    - If the new `edges_seen` equals the latched count → FIRE_LO; otherwise → ARMED.
    - `arm`=0 → IDLE. This has priority over qualification in the same cycle.
    - FILTER_CYCLES=1 qualifies in the edge cycle itself (ARMED goes straight to the qualified action).
  - FIRE_LO: `trig_out`=1; wait for `done_in`=0 (generator has left its previous DONE) → FIRE_HI.
  - FIRE_HI: `trig_out`=1; wait for `done_in`=1 → HOLDOFF.
  - HOLDOFF: `trig_out`=0; count HOLDOFF_CYCLES → ARMED if `arm`, otherwise IDLE. `edges_seen` is cleared on exit.
- `arm` deassertion during FIRE_LO/FIRE_HI/HOLDOFF does not abort the shot.
- Timeout: a wait counter restarts on entry to each FIRE state. Reaching DONE_TIMEOUT → pulse `timeout` and go to HOLDOFF.
- `edges_seen` saturates at 2**CNT_W−1.
- `rst` mid-operation → IDLE next cycle, `trig_out`=0, counters cleared.

## Timing
- Reset values: `trig_out`, `armed`, `fired`, `timeout` = 0; `edges_seen` = 0; state IDLE.
- All outputs are registered.
- Latency: `trig_raw` first sampled at its new level on edge k, and that edge is the firing edge → `trig_out` and `fired` high after edge k+1+FILTER_CYCLES.
- `trig_out` falls on the edge after `done_in` is seen high in FIRE_HI.
- Holdoff: the first new edge can be accepted HOLDOFF_CYCLES+1 cycles after `trig_out` falls.
- Edges arriving in FIRE/HOLDOFF are ignored, not queued.
- An edge sampled in the same cycle as IDLE→ARMED is ignored.

## Structure
- Package `glitch_pkg`:
  - `qual_state_e` enum: IDLE, ARMED, QUAL, FIRE_LO, FIRE_HI, HOLDOFF.
  - `edge_sel_e`: RISING = 0, FALLING = 1.
  - Shared clock-rate constants.
- Sub-module `trig_sync`:
  - 2-FF synchronizer plus edge detector.
  - Outputs: synced level, rise pulse, fall pulse.
  - Reused for any other asynchronous inputs.

## Test plan
- FILTER_CYCLES=4, `edge_count`=1, rising: `trig_raw` 0→1 held 10 cycles → `trig_out` and `fired` high exactly 5 cycles after the first sampling edge; `done_in` 1→0→1 → `trig_out` low next cycle.
- Glitch rejection: `trig_raw` high for 3 cycles (FILTER_CYCLES=4) → no qualified edge, `edges_seen`=0. Then a high held 4 cycles → `edges_seen`=1.
- Nth edge: `edge_count`=3, falling, five clean falling edges → fires on the third. Edges 4–5 fall inside HOLDOFF (HOLDOFF_CYCLES=1024) and are ignored; `edges_seen` is 0 after holdoff.
- Handshake ordering: `done_in` held 1 at fire time → remains in FIRE_LO with `trig_out`=1. Drop `done_in`, then raise it → HOLDOFF. With `edge_count`=0, fires on the first edge.
- Timeout: DONE_TIMEOUT=16, `done_in` stuck 1 → `timeout` pulse 16 cycles after entering FIRE_LO, `trig_out` low, HOLDOFF entered.
- Reset and arm: `rst` asserted in FIRE_HI → next cycle IDLE with all outputs 0. `arm` dropped in QUAL → IDLE, no count. `arm` dropped in FIRE_HI → shot completes, IDLE after holdoff.
